ex_muldiv_seq: RTL and testbench
================================

Name: ex_muldiv_seq

Overview:
- Multi-cycle sequencer for RV32M multiply/divide/remainder operations in the EX stage.
- Accepts one M-extension operation from the EX control path and runs an iterative shift-add multiply or restoring divide.
- Holds the pipeline with a stall request until the result is ready.
- Presents the result for exactly one cycle so EX/MEM can capture it alongside ALU results.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  EX holds a valid M-extension instruction
- op  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- rs1  in  XLEN  forwarded operand A
- rs2  in  XLEN  forwarded operand B
- flush  in  1  kill the EX instruction (branch/jalr redirect)
- stall  out  1  freeze IF/ID/EX, combinational
- done  out  1  result valid this cycle, registered
- result  out  XLEN  selected result, registered

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; done=0; result=0; counter=0; internal registers cleared.
  - stall=0 while rst is high.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - Accept when start=1 and flush=0. This is cycle T0.
  - On accept, latch op and operand magnitudes, plus sign flags for signed ops (MUL counts as signed/signed; the low word is unaffected).
  - Special divide case at T0 (divisor==0, or signed overflow rs1=0x80000000 with rs2=0xFFFFFFFF): go straight to DONE. done is high in T1.
  - Otherwise go to RUN with counter=0.
- RUN:
  - One iteration per cycle; counter increments.
  - Multiply: 2*XLEN product, one shift-add per cycle.
  - Divide: restoring divide using an XLEN+1-bit subtract, one quotient bit per cycle.
  - After the iteration with counter==XLEN-1, go to DONE. done is high in T(XLEN+1), i.e. T33 by default.
- DONE:
  - done=1 for exactly one cycle; result holds the sign-corrected value; next state is IDLE.
  - start is ignored in DONE, because the same instruction is still in EX.
- stall = (IDLE & start & ~flush) | RUN. stall is 0 in DONE so the pipeline advances that cycle.
- Result selection:
  - MUL returns the low word; MULH, MULHSU and MULHU return the high word.
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
  - Signed quotient sign = sign(rs1) XOR sign(rs2). Signed remainder sign = sign(rs1).
- Special values:
  - Divide by zero: quotient=all ones; remainder=rs1.
  - Signed overflow: quotient=0x80000000; remainder=0.
- result holds its last value after done falls. Consumers use it only when done=1.
- flush:
  - In any state, next state is IDLE and no done is issued. flush wins over start.
  - Cancels an in-flight RUN. stall drops in the same cycle flush is asserted during RUN.
  - A flush in the DONE cycle suppresses nothing: done is already registered, and the pipeline flush logic discards it.
- Back-to-back operations: a new start is accepted in the IDLE cycle immediately after DONE.
- Reset mid-operation: immediate return to IDLE, outputs cleared, no done.
- Operand changes on rs1/rs2 after T0 are ignored.

Decomposition:
- Shared package muldiv_pkg:
  - op encoding enum muldiv_op_e (the funct3 values above).
  - state enum muldiv_state_e.
  - constants DIV_ZERO_Q (all ones) and INT_MIN (0x80000000).
- No sub-module: the single module contains the FSM plus the shared iterative datapath (one adder reused for add and subtract).
- The team's EX control interface gains an M-extension select so that start is derived in decode.

Test Plan:
- MUL, rs1=7, rs2=0xFFFFFFFD (-3) -> stall high T0..T32, done=1 at T33, result=0xFFFFFFEB.
- MULH, rs1=rs2=0x80000000 -> result=0x40000000. MULHU with the same operands -> 0x40000000. MULHSU, rs1=0xFFFFFFFF, rs2=2 -> 0xFFFFFFFF.
- DIV, rs1=0xFFFFFFF9 (-7), rs2=2 -> 0xFFFFFFFD at T33. REM on the same operands -> 0xFFFFFFFF. DIVU, 100/7 -> 14. REMU -> 2.
- DIVU, rs1=0x1234, rs2=0 -> done at T1, result=0xFFFFFFFF. REM, 0x1234/0 -> 0x1234. DIV, 0x80000000/0xFFFFFFFF -> 0x80000000 at T1; REM on the same operands -> 0.
- flush at T10 of a DIV -> stall=0 at T10, no done ever. New MUL 3*5 with start at T11 -> accepted, result=15 at T44.
- rst pulsed asynchronously mid-RUN (T5) -> stall, done and result go to 0 immediately. start=0 afterwards -> done stays 0. Back-to-back MUL then DIVU: second accepted at T34, its done at T67; start held high during DONE causes no re-execution.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: funct3 encoding,
// sequencer states and the canonical special-case result values.
package muldiv_pkg;

    localparam int MULDIV_XLEN = 32;

    // funct3 encoding of the M-extension operations
    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } muldiv_state_e;

    // Quotient returned for a divide by zero
    localparam logic [MULDIV_XLEN-1:0] DIV_ZERO_Q = '1;
    // Most negative signed value (dividend of the signed-overflow case)
    localparam logic [MULDIV_XLEN-1:0] INT_MIN = {1'b1, {(MULDIV_XLEN-1){1'b0}}};

    // Divide-family ops all have funct3[2] set
    function automatic logic op_is_div(input muldiv_op_e op);
        return op[2];
    endfunction

endpackage

// File: rtl/ex_muldiv_seq.sv
// EX-stage multi-cycle sequencer for RV32M. Operands are reduced to magnitudes
// at accept time; one shared XLEN+1-bit adder performs either a shift-add
// multiply step or a restoring divide step per cycle; the sign is restored when
// the final iteration writes the registered result.
module ex_muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int XLEN = MULDIV_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0]   LAST_ITER = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_e   state_q;
    muldiv_op_e      op_q;
    logic            neg_a_q;
    logic            neg_b_q;
    logic [XLEN-1:0] mcand_q;   // multiplicand magnitude, or divisor magnitude
    logic [XLEN-1:0] hi_q;      // product high half, or partial remainder
    logic [XLEN-1:0] lo_q;      // multiplier / product low half, or dividend / quotient
    logic [CW-1:0]   cnt_q;
    logic            done_q;
    logic [XLEN-1:0] result_q;

    // Incoming-operation decode
    muldiv_op_e      in_op;
    logic            in_div;
    logic            in_sgn_a;
    logic            in_sgn_b;
    logic            in_neg_a;
    logic            in_neg_b;
    logic            in_zero;
    logic            in_ovf;
    logic [XLEN-1:0] in_mag_a;
    logic [XLEN-1:0] in_mag_b;
    logic [XLEN-1:0] special_res;

    assign in_op = muldiv_op_e'(op);

    // Classify the operation at accept time: signedness, magnitudes, special divides
    always_comb begin
        in_div   = op_is_div(in_op);
        in_sgn_a = (in_op == OP_MUL) || (in_op == OP_MULH) || (in_op == OP_MULHSU) ||
                   (in_op == OP_DIV) || (in_op == OP_REM);
        in_sgn_b = (in_op == OP_MUL) || (in_op == OP_MULH) ||
                   (in_op == OP_DIV) || (in_op == OP_REM);
        in_neg_a = in_sgn_a && rs1[XLEN-1];
        in_neg_b = in_sgn_b && rs2[XLEN-1];
        in_mag_a = in_neg_a ? (-rs1) : rs1;
        in_mag_b = in_neg_b ? (-rs2) : rs2;
        in_zero  = in_div && (rs2 == '0);
        in_ovf   = ((in_op == OP_DIV) || (in_op == OP_REM)) &&
                   (rs1 == MIN_NEG) && (rs2 == '1);
        special_res = '0;
        if (in_zero) begin
            special_res = ((in_op == OP_DIV) || (in_op == OP_DIVU)) ? '1 : rs1;
        end else if (in_ovf) begin
            special_res = (in_op == OP_DIV) ? MIN_NEG : '0;
        end
    end

    // Shared iteration datapath
    logic            is_mul;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   add_a;
    logic [XLEN:0]   add_b;
    logic            add_cin;
    logic [XLEN:0]   sum;
    logic [XLEN-1:0] hi_d;
    logic [XLEN-1:0] lo_d;

    // One adder: hi+mcand for a multiply step, {rem,next bit}-divisor for a divide step
    always_comb begin
        is_mul  = ~op_is_div(op_q);
        shifted = {hi_q, lo_q[XLEN-1]};
        if (is_mul) begin
            add_a   = {1'b0, hi_q};
            add_b   = lo_q[0] ? {1'b0, mcand_q} : '0;
            add_cin = 1'b0;
        end else begin
            add_a   = shifted;
            add_b   = ~{1'b0, mcand_q};
            add_cin = 1'b1;
        end
        sum = add_a + add_b + {{XLEN{1'b0}}, add_cin};
        if (is_mul) begin
            // product register shifts right, carry enters the top
            hi_d = sum[XLEN:1];
            lo_d = {sum[0], lo_q[XLEN-1:1]};
        end else begin
            // the remainder stays below the divisor, so sum[XLEN] is the borrow
            hi_d = sum[XLEN] ? shifted[XLEN-1:0] : sum[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], ~sum[XLEN]};
        end
    end

    // Sign correction of the value produced by the last iteration
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quot_s;
    logic [XLEN-1:0]   rem_s;
    logic [XLEN-1:0]   final_res;

    // Restore signs and pick the word the instruction asks for
    always_comb begin
        prod_s = (neg_a_q ^ neg_b_q) ? (-{hi_d, lo_d}) : {hi_d, lo_d};
        quot_s = (neg_a_q ^ neg_b_q) ? (-lo_d) : lo_d;
        rem_s  = neg_a_q ? (-hi_d) : hi_d;
        case (op_q)
            OP_MUL:                       final_res = prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              final_res = quot_s;
            default:                      final_res = rem_s;
        endcase
    end

    // Sequencer FSM with registered done/result; flush always returns to IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_MUL;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            mcand_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (flush) begin
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start) begin
                            op_q    <= in_op;
                            neg_a_q <= in_neg_a;
                            neg_b_q <= in_neg_b;
                            hi_q    <= '0;
                            cnt_q   <= '0;
                            // dividend goes through lo; the multiply order does not matter
                            mcand_q <= in_div ? in_mag_b : in_mag_a;
                            lo_q    <= in_div ? in_mag_a : in_mag_b;
                            if (in_zero || in_ovf) begin
                                result_q <= special_res;
                                done_q   <= 1'b1;
                                state_q  <= ST_DONE;
                            end else begin
                                state_q  <= ST_RUN;
                            end
                        end
                    end
                    ST_RUN: begin
                        hi_q  <= hi_d;
                        lo_q  <= lo_d;
                        cnt_q <= cnt_q + CW'(1);
                        if (cnt_q == LAST_ITER) begin
                            result_q <= final_res;
                            done_q   <= 1'b1;
                            state_q  <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        // the finished instruction is still in EX; do not restart it
                        state_q <= ST_IDLE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign stall  = ~rst & ~flush &
                    (((state_q == ST_IDLE) & start) | (state_q == ST_RUN));
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Scoreboard bench for ex_muldiv_seq: stimulus pushes the reference result and
// the cycle it is due; an independent monitor pops on every done.
module tb_ex_muldiv_seq;
    import muldiv_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        flush;
    logic        stall;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] res;
        int          due;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    ex_muldiv_seq #(.XLEN(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .rs1    (rs1),
        .rs2    (rs2),
        .flush  (flush),
        .stall  (stall),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference results straight from the RV32M definitions
    function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
        longint    sa, sb, ua, ub;
        logic [63:0] p;
        int        ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        ia = $signed(a);
        ib = $signed(b);
        case (f3)
            3'd0: begin p = 64'(sa * sb); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return DIV_ZERO_Q;
                if (a == INT_MIN && b == 32'hFFFF_FFFF) return INT_MIN;
                return 32'(ia / ib);
            end
            3'd5: begin
                if (b == 32'd0) return DIV_ZERO_Q;
                return a / b;
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == INT_MIN && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(ia % ib);
            end
            default: begin
                if (b == 32'd0) return a;
                return a % b;
            end
        endcase
    endfunction

    // Cycles from accept to done: special divides finish at once, others after 32 steps
    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] b);
        if (f3 >= 3'd4) begin
            if (b == 32'd0) return 1;
            if ((f3 == 3'd4 || f3 == 3'd6) && a == INT_MIN && b == 32'hFFFF_FFFF) return 1;
        end
        return 33;
    endfunction

    // Monitor: every done must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got result %h, expected no done (cycle %0d)",
                         result, cyc);
            end else begin
                mon_e = sb_q.pop_front();
                chk("result", result, mon_e.res);
                chk("done_cycle", 32'(cyc), 32'(mon_e.due));
                chk("stall_in_done", {31'd0, stall}, 32'd0);
                $display("txn op=%0d result=%h expected=%h cycle=%0d due=%0d",
                         mon_e.op, result, mon_e.res, cyc, mon_e.due);
            end
        end
    end

    // Issue one op at the current cycle (T0) and wait for its done.
    // hold keeps start/operands steady until the cycle after DONE.
    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input bit hold);
        exp_t e;
        int   t0;
        int   lat;
        bit   seen;
        t0    = cyc;
        lat   = ref_lat(f3, a, b);
        start = 1'b1;
        op    = f3;
        rs1   = a;
        rs2   = b;
        e.op  = f3;
        e.res = ref_res(f3, a, b);
        e.due = t0 + lat;
        sb_q.push_back(e);
        #1;
        chk("stall_t0", {31'd0, stall}, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (!hold) begin
                start = 1'b0;
                op    = 3'($urandom_range(0, 7));
                rs1   = $urandom;
                rs2   = $urandom;
            end
            if (done) seen = 1'b1;
            else if (i == 15) chk("stall_run", {31'd0, stall}, 32'd1);
        end
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    logic [2:0]  d_op[12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                              3'd5, 3'd6, 3'd4, 3'd6};
    logic [31:0] d_a[12]  = '{32'd7, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF,
                              32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                              32'h1234, 32'h1234, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] d_b[12]  = '{32'hFFFF_FFFD, 32'h8000_0000, 32'h8000_0000, 32'd2,
                              32'd2, 32'd2, 32'd7, 32'd7,
                              32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

    initial begin
        int          t0;
        int          dones;
        logic [2:0]  r_op;
        logic [31:0] r_a;
        logic [31:0] r_b;

        rst   = 1'b1;
        start = 1'b1;
        op    = 3'd0;
        rs1   = 32'd1;
        rs2   = 32'd1;
        flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_stall", {31'd0, stall}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_result", result, 32'd0);
        start = 1'b0;
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed cases
        for (int i = 0; i < 12; i++) do_op(d_op[i], d_a[i], d_b[i], 1'b0);

        // Back-to-back with start held through DONE
        do_op(3'd0, 32'd1234, 32'd5678, 1'b1);
        do_op(3'd5, 32'hDEAD_BEEF, 32'd97, 1'b1);

        // Flush a DIV at T10, then a MUL accepted at T11
        t0    = cyc;
        start = 1'b1;
        op    = 3'd4;
        rs1   = 32'd1_000_000;
        rs2   = 32'd3;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        #1;
        chk("stall_on_flush", {31'd0, stall}, 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_t11_cycle", 32'(cyc - t0), 32'd11);
        do_op(3'd0, 32'd3, 32'd5, 1'b0);

        // Asynchronous reset at T5 of a DIV
        start = 1'b1;
        op    = 3'd4;
        rs1   = 32'hFFFF_0000;
        rs2   = 32'd13;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("midrun_rst_stall", {31'd0, stall}, 32'd0);
        chk("midrun_rst_done", {31'd0, done}, 32'd0);
        chk("midrun_rst_result", result, 32'd0);
        start = 1'b0;
        #2;
        rst = 1'b0;
        dones = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        chk("no_done_after_rst", 32'(dones), 32'd0);

        // Randomized operations, biased toward the divide corner cases
        for (int n = 0; n < 30; n++) begin
            r_op = 3'($urandom_range(0, 7));
            r_a  = $urandom;
            r_b  = $urandom;
            case ($urandom_range(0, 9))
                0: r_b = 32'd0;
                1: begin r_a = INT_MIN; r_b = 32'hFFFF_FFFF; end
                2: r_b = 32'($urandom_range(1, 15));
                3: r_a = 32'($urandom_range(0, 255));
                default: ;
            endcase
            do_op(r_op, r_a, r_b, bit'($urandom_range(0, 1)));
        end

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
